// File: rtl/paralelo_serial_tx_if.sv
// ============================================================================
// Module   : paralelo_serial_tx_if
// Purpose  : valid/ready word handshake into the paralelo_serial_tx serializer
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface paralelo_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

`default_nettype wire

// File: rtl/paralelo_serial_tx.sv
// ============================================================================
// Module   : paralelo_serial_tx
// Purpose  : MSB-first word serializer with COM training run and 1-entry buffer
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module paralelo_serial_tx #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] COM   = 8'hBC,
  parameter logic [WIDTH-1:0] IDLE  = 8'h7C,
  parameter int               N_COM = 4
) (
  input  wire logic           clk_32f,
  input  wire logic           reset,
  paralelo_serial_tx_if.slave up,
  output logic                data_out,
  output logic                word_start,
  output logic                active,
  output logic [3:0]          com_cnt_out
);

  localparam int               CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_PEN   = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [3:0]       C_NCOM  = 4'(N_COM);

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t            state_q,      state_d;
  logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
  logic [WIDTH-1:0]  shreg_q,      shreg_d;
  logic              data_out_q,   data_out_d;
  logic              word_start_q, word_start_d;
  logic [3:0]        com_cnt_q,    com_cnt_d;
  logic              buf_full_q,   buf_full_d;
  logic [WIDTH-1:0]  buffer_q,     buffer_d;

  logic              w_load;
  logic              w_ready;
  logic              w_xfer;
  logic [WIDTH-1:0]  w_next_word;
  logic [CNT_W-1:0]  w_bit_idx;

  assign w_ready   = (state_q != ST_RST) && !buf_full_q;
  assign w_xfer    = up.valid_in && w_ready;
  assign w_load    = (state_q == ST_RST) || (bit_cnt_q == C_LAST);
  assign w_bit_idx = C_PEN - bit_cnt_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    data_out_d   = data_out_q;
    word_start_d = 1'b0;
    com_cnt_d    = com_cnt_q;
    buf_full_d   = buf_full_q;
    buffer_d     = buffer_q;
    w_next_word  = IDLE;

    if (w_load) begin
      // Training has priority; once COMs are done, the buffer drains before IDLE.
      if ((state_q != ST_ACTIVE) && (com_cnt_q < C_NCOM)) begin
        w_next_word = COM;
        com_cnt_d   = com_cnt_q + 4'd1;
        state_d     = ST_TRAIN;
      end else begin
        state_d = ST_ACTIVE;
        if (buf_full_q) begin
          w_next_word = buffer_q;
          buf_full_d  = 1'b0;
        end
      end
      bit_cnt_d    = '0;
      shreg_d      = w_next_word;
      data_out_d   = w_next_word[WIDTH-1];
      word_start_d = 1'b1;
    end else begin
      bit_cnt_d  = bit_cnt_q + C_ONE;
      data_out_d = shreg_q[w_bit_idx];
    end

    // Cannot collide with a drain: ready is low whenever the buffer is full.
    if (w_xfer) begin
      buffer_d   = up.data_in;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q      <= ST_RST;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      data_out_q   <= 1'b0;
      word_start_q <= 1'b0;
      com_cnt_q    <= 4'd0;
      buf_full_q   <= 1'b0;
      buffer_q     <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      word_start_q <= word_start_d;
      com_cnt_q    <= com_cnt_d;
      buf_full_q   <= buf_full_d;
      buffer_q     <= buffer_d;
    end
  end

  assign up.ready_out  = w_ready;
  assign data_out      = data_out_q;
  assign word_start    = word_start_q;
  assign active        = (state_q == ST_ACTIVE);
  assign com_cnt_out   = com_cnt_q;

endmodule

`default_nettype wire
